// File: rtl/spi_flash_pkg.sv
// Shared state encoding, opcodes and phase lengths for the SPI flash reader.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_HOLD
    } state_t;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;
    localparam int DATA_BITS  = 32;

    // Serial data arrives first byte in the top byte; the response is little-endian.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: CLK_DIV clk cycles per half-period, mode 0 (idles low),
// with single-cycle strobes on the clk edges where spi_clk rises and falls.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic rise,
    output logic fall,
    output logic spi_clk
);

    logic [7:0] div_cnt;
    logic       terminal;

    assign terminal = enable && (div_cnt == 8'(CLK_DIV - 1));
    assign rise     = terminal && !spi_clk;
    assign fall     = terminal && spi_clk;

    // Dropping enable restarts the divider so every transfer begins with a full low phase.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            spi_clk <= !spi_clk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// Single-word SPI flash reader: CMD, 24-bit ADDR, optional DUMMY, 32-bit DATA.
// Define SPI_FLASH_READER_FAST_READ_EN to use FAST READ (0x0B + 8 dummy bits).
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_HOLD = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        spi_csb,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] OPCODE    = OP_FAST_READ;
    localparam bit         USE_DUMMY = 1'b1;
`else
    localparam logic [7:0] OPCODE    = OP_READ;
    localparam bit         USE_DUMMY = 1'b0;
`endif

    state_t      state, state_nxt;
    logic [4:0]  bit_cnt, bit_last;
    logic [3:0]  hold_cnt;
    logic [31:0] tx_sh, rx_sh;
    logic        shifting, rise, fall, bit_done, accept;

    assign shifting  = (state == ST_CMD) || (state == ST_ADDR) ||
                       (state == ST_DUMMY) || (state == ST_DATA);
    assign req_ready = (state == ST_IDLE) && !wb_rst_i;
    assign accept    = req_valid && req_ready;
    assign bit_done  = fall && (bit_cnt == bit_last);
    assign busy      = (state != ST_IDLE);
    assign spi_csb   = !shifting;
    assign spi_mosi  = ((state == ST_CMD) || (state == ST_ADDR)) && tx_sh[31];

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .enable  (shifting),
        .rise    (rise),
        .fall    (fall),
        .spi_clk (spi_clk)
    );

    always_comb begin
        bit_last = '0;
        case (state)
            ST_CMD:   bit_last = 5'(CMD_BITS - 1);
            ST_ADDR:  bit_last = 5'(ADDR_BITS - 1);
            ST_DUMMY: bit_last = 5'(DUMMY_BITS - 1);
            ST_DATA:  bit_last = 5'(DATA_BITS - 1);
            default:  bit_last = '0;
        endcase
    end

    // The IDLE cycle that accepts the next request is itself a chip-select-high
    // cycle, so HOLD lasts CS_HOLD-1 cycles and is skipped entirely when CS_HOLD is 1.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)   state_nxt = ST_CMD;
            ST_CMD:   if (bit_done) state_nxt = ST_ADDR;
            ST_ADDR:  if (bit_done) state_nxt = USE_DUMMY ? ST_DUMMY : ST_DATA;
            ST_DUMMY: if (bit_done) state_nxt = ST_DATA;
            ST_DATA:  if (bit_done) state_nxt = (CS_HOLD > 1) ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (hold_cnt == 4'(CS_HOLD - 2)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= (state_nxt != state) ? 5'd0 : (fall ? bit_cnt + 5'd1 : bit_cnt);
            hold_cnt  <= (state == ST_HOLD) ? hold_cnt + 4'd1 : 4'd0;
            rsp_valid <= (state == ST_DATA) && bit_done;
            if ((state == ST_DATA) && bit_done)
                rsp_data <= byte_swap32(rx_sh);
        end
    end

    // Shift registers carry pure data; the FSM decides when their contents matter.
    always_ff @(posedge wb_clk_i) begin
        if (accept)
            tx_sh <= {OPCODE, req_addr};
        else if (fall)
            tx_sh <= {tx_sh[30:0], 1'b0};
        if (rise && (state == ST_DATA))
            rx_sh <= {rx_sh[30:0], spi_miso};
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench: two readers (CLK_DIV=2/CS_HOLD=2 and CLK_DIV=1/CS_HOLD=3) each talking to a flash model.
`timescale 1ns/1ps
module tb_spi_flash_reader;

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam int         DUMMY = 8;
    localparam logic [7:0] OPC   = 8'h0B;
`else
    localparam int         DUMMY = 0;
    localparam logic [7:0] OPC   = 8'h03;
`endif
    localparam int DIV0 = 2, HOLD0 = 2, DIV1 = 1, HOLD1 = 3;

    typedef struct {
        logic [31:0] d;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, busy, csb, sclk, mosi, miso;
    logic [23:0] req_addr0, req_addr1;
    logic [31:0] rsp_data0, rsp_data1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_flash_reader #(.CLK_DIV(DIV0), .CS_HOLD(HOLD0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr0), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data0), .spi_csb(csb[0]),
        .spi_clk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]), .busy(busy[0]));

    spi_flash_reader #(.CLK_DIV(DIV1), .CS_HOLD(HOLD1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr1), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data1), .spi_csb(csb[1]),
        .spi_clk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]), .busy(busy[1]));

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h11;
            24'h000001: return 8'h22;
            24'h000002: return 8'h33;
            24'h000003: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
    endfunction

    function automatic logic miso_bit(input logic [31:0] sh, input logic [7:0] bc);
        int d;
        int k;
        logic [7:0] b;
        d = (sh[31:24] == 8'h0B) ? 8 : 0;
        if (int'(bc) < 32 + d) return 1'b0;
        k = int'(bc) - 32 - d;
        b = flash_byte(sh[23:0] + 24'(k / 8));
        return b[7 - (k % 8)];
    endfunction

    // Flash model: captures opcode/address on spi_clk rises, presents data bits for the next rise.
    for (genvar g = 0; g < 2; g++) begin : fm
        logic [7:0]  bitc = 8'd0;
        logic [31:0] in_sh = 32'd0;
        logic [31:0] last_cmd = 32'd0;
        logic        sclk_q = 1'b0, csb_q = 1'b1;
        int low_cnt = 0, hi_cnt = 0, bad = 0, idle_bad = 0;
        int last_rises = 0, last_low = 0, last_hi = 0, last_bad = 0;

        assign miso[g] = csb[g] ? 1'b0 : miso_bit(in_sh, bitc);

        always @(posedge clk) begin
            sclk_q <= sclk[g];
            csb_q  <= csb[g];
            if (csb[g]) begin
                bitc    <= 8'd0;
                low_cnt <= 0;
                bad     <= 0;
                hi_cnt  <= hi_cnt + 1;
                if (sclk[g] || mosi[g]) idle_bad <= idle_bad + 1;
                if (!csb_q) begin
                    last_rises <= int'(bitc);
                    last_low   <= low_cnt;
                    last_cmd   <= in_sh;
                    last_bad   <= bad;
                end
            end else begin
                low_cnt <= low_cnt + 1;
                hi_cnt  <= 0;
                if (csb_q) last_hi <= hi_cnt;
                if (sclk[g] && !sclk_q) begin
                    bitc <= bitc + 8'd1;
                    if (bitc < 8'd32) in_sh <= {in_sh[30:0], mosi[g]};
                    else if (mosi[g]) bad <= bad + 1;
                end
            end
        end
    end

    task automatic issue(input int ch, input logic [23:0] a, output bit ok);
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[ch]) ok = 1'b1;
        end
        if (ok) begin
            req_valid[ch] = 1'b1;
            if (ch == 0) req_addr0 = a; else req_addr1 = a;
            e.d   = exp_word(a);
            e.acc = cyc;
            e.lat = 1 + 2 * ((ch == 0) ? DIV0 : DIV1) * (64 + DUMMY);
            if (ch == 0) q0.push_back(e); else q1.push_back(e);
            @(negedge clk);
            req_valid[ch] = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int ch, input int max, output bit got, output logic [31:0] data,
                            output int lat, output logic [31:0] exp_d, output int exp_l);
        exp_t e;
        got = 1'b0; data = '0; lat = 0; exp_d = '0; exp_l = -1;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[ch]) begin
                got  = 1'b1;
                data = (ch == 0) ? rsp_data0 : rsp_data1;
                if (ch == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); exp_d = e.d; exp_l = e.lat; lat = cyc - e.acc;
                end else if (ch == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); exp_d = e.d; exp_l = e.lat; lat = cyc - e.acc;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        req_addr0 = '0;
        req_addr1 = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
        checks++; if (csb !== 2'b11) begin errors++; $display("FAIL reset_csb got %b want 11", csb); end
        checks++; if (sclk !== 2'b00) begin errors++; $display("FAIL reset_sclk got %b want 00", sclk); end
        checks++; if (mosi !== 2'b00) begin errors++; $display("FAIL reset_mosi got %b want 00", mosi); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", busy); end
        checks++; if (rsp_data0 !== 32'h0 || rsp_data1 !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_data got %h/%h want 0", rsp_data0, rsp_data1); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL ready_after_reset got %b want 11", req_ready); end
    endtask

    task automatic test_basic_read();
        bit ok, got;
        logic [31:0] d, ed;
        int l, el;
        issue(0, 24'h000000, ok);
        wait_rsp(0, 2000, got, d, l, ed, el);
        checks++; if (!ok || !got) begin errors++; $display("FAIL basic_timeout got %0d/%0d want 1/1", ok, got); end
        checks++; if (d !== 32'h44332211) begin errors++; $display("FAIL basic_data got %h want 44332211", d); end
        checks++; if (d !== ed) begin errors++; $display("FAIL basic_sb_data got %h want %h", d, ed); end
        checks++; if (l !== el) begin errors++; $display("FAIL basic_latency got %0d want %0d", l, el); end
        @(negedge clk);
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", rsp_valid[0]); end
        repeat (4) @(negedge clk);
        checks++; if (rsp_data0 !== d) begin errors++; $display("FAIL basic_data_hold got %h want %h", rsp_data0, d); end
        checks++; if (fm[0].last_cmd !== {OPC, 24'h000000}) begin
            errors++; $display("FAIL basic_mosi got %h want %h", fm[0].last_cmd, {OPC, 24'h000000}); end
        checks++; if (fm[0].last_rises != 64 + DUMMY) begin
            errors++; $display("FAIL basic_sclk_rises got %0d want %0d", fm[0].last_rises, 64 + DUMMY); end
        checks++; if (fm[0].last_low != 2 * DIV0 * (64 + DUMMY)) begin
            errors++; $display("FAIL basic_csb_low got %0d want %0d", fm[0].last_low, 2 * DIV0 * (64 + DUMMY)); end
        checks++; if (fm[0].last_bad != 0) begin errors++; $display("FAIL basic_mosi_late got %0d want 0", fm[0].last_bad); end
    endtask

    task automatic test_clk_div1();
        bit ok, got;
        logic [31:0] d, ed;
        int l, el, toggles;
        logic prev;
        issue(1, 24'h000100, ok);
        toggles = 0;
        prev = sclk[1];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sclk[1] !== prev) toggles++;
            prev = sclk[1];
        end
        checks++; if (toggles != 8) begin errors++; $display("FAIL div1_sclk_toggles got %0d want 8", toggles); end
        wait_rsp(1, 2000, got, d, l, ed, el);
        checks++; if (!ok || !got) begin errors++; $display("FAIL div1_timeout got %0d/%0d want 1/1", ok, got); end
        checks++; if (d !== 32'hA7A6A5A4) begin errors++; $display("FAIL div1_data got %h want a7a6a5a4", d); end
        checks++; if (l != 129 + 16 * (DUMMY / 8)) begin
            errors++; $display("FAIL div1_latency got %0d want %0d", l, 129 + 16 * (DUMMY / 8)); end
    endtask

    task automatic test_patterns();
        logic [23:0] addrs [3];
        bit ok, got;
        logic [31:0] d, ed;
        int l, el;
        addrs[0] = 24'h000004; addrs[1] = 24'hABCDEF; addrs[2] = 24'hFFFFFE;
        for (int i = 0; i < 3; i++) begin
            issue(0, addrs[i], ok);
            wait_rsp(0, 2000, got, d, l, ed, el);
            checks++; if (!got || d !== ed) begin
                errors++; $display("FAIL pattern_data addr %h got %h want %h", addrs[i], d, ed); end
            checks++; if (l != el) begin
                errors++; $display("FAIL pattern_latency addr %h got %0d want %0d", addrs[i], l, el); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n_acc, n_rsp, last_acc;
        logic [31:0] d;
        n_acc = 0; n_rsp = 0; last_acc = 0;
        req_addr0 = 24'h000200;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 3000 && n_rsp < 2; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                n_rsp++;
                d = rsp_data0;
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    checks++; if (d !== e.d) begin errors++; $display("FAIL b2b_data got %h want %h", d, e.d); end
                    checks++; if (cyc - e.acc != e.lat) begin
                        errors++; $display("FAIL b2b_latency got %0d want %0d", cyc - e.acc, e.lat); end
                end else begin
                    checks++; errors++; $display("FAIL b2b_extra_rsp got %h want none", d);
                end
            end
            if (req_valid[0] && req_ready[0]) begin
                e.d = exp_word(req_addr0); e.acc = cyc; e.lat = 1 + 2 * DIV0 * (64 + DUMMY);
                q0.push_back(e);
                n_acc++;
                last_acc = cyc;
            end else if (n_acc == 1 && cyc == last_acc + 5) begin
                req_addr0 = 24'h000300;
            end else if (n_acc == 2 && req_valid[0]) begin
                req_valid[0] = 1'b0;
                req_addr0 = 24'h000400;
            end
        end
        req_valid[0] = 1'b0;
        checks++; if (n_rsp != 2 || n_acc != 2) begin
            errors++; $display("FAIL b2b_count got acc %0d rsp %0d want 2/2", n_acc, n_rsp); end
        checks++; if (fm[0].last_hi != HOLD0) begin
            errors++; $display("FAIL b2b_csb_gap got %0d want %0d", fm[0].last_hi, HOLD0); end
    endtask

    task automatic test_reset_abort();
        bit ok, got, reached;
        logic [31:0] d, ed;
        int l, el, pulses;
        issue(0, 24'h000010, ok);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (fm[0].bitc >= 8'd12) reached = 1'b1;
        end
        checks++; if (!ok || !reached) begin errors++; $display("FAIL abort_reach_addr got %0d/%0d want 1/1", ok, reached); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (csb[0] !== 1'b1) begin errors++; $display("FAIL abort_csb got %b want 1", csb[0]); end
        checks++; if (sclk[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL abort_idle got sclk %b busy %b want 0/0", sclk[0], busy[0]); end
        rst = 1'b0;
        if (q0.size() > 0) void'(q0.pop_back());
        pulses = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_rsp got %0d want 0", pulses); end
        issue(0, 24'h000000, ok);
        wait_rsp(0, 2000, got, d, l, ed, el);
        checks++; if (!got || d !== 32'h44332211) begin
            errors++; $display("FAIL abort_next_data got %h want 44332211", d); end
        checks++; if (l != el) begin errors++; $display("FAIL abort_next_latency got %0d want %0d", l, el); end
        checks++; if (fm[0].idle_bad != 0 || fm[1].idle_bad != 0) begin
            errors++; $display("FAIL idle_lines got %0d/%0d want 0/0", fm[0].idle_bad, fm[1].idle_bad); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_clk_div1();
        test_patterns();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, meaning clk cycles per SPI clock half-period (legal range 1..255).
REQ-002 SHALL provide parameter CS_HOLD, default 2, meaning minimum clk cycles spi_csb stays high between transactions (legal range 1..15).
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: read request present.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted when both req_valid and req_ready are high.
REQ-007 SHALL have port req_addr, input, 24 bits: flash byte address.
REQ-008 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse marking rsp_data valid.
REQ-009 SHALL have port rsp_data, output, 32 bits: read word.
REQ-010 SHALL have port spi_csb, output, 1 bit: flash chip select, active low.
REQ-011 SHALL have port spi_clk, output, 1 bit: SPI clock, mode 0.
REQ-012 SHALL have port spi_mosi, output, 1 bit: serial data to flash (io0).
REQ-013 SHALL have port spi_miso, input, 1 bit: serial data from flash (io1).
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CMD, ADDR, DUMMY, DATA, HOLD.
- IDLE: req_ready=1.
- Acceptance -> CMD.
- CMD (8 bits) -> ADDR (24 bits) -> DUMMY (0 or 8 bits) -> DATA (32 bits) -> HOLD (CS_HOLD cycles) -> IDLE.
REQ-016 SHALL register req_addr at acceptance; later changes to req_addr SHALL have no effect on the transaction in progress.
REQ-017 SHALL drive spi_csb low from the cycle after acceptance (T+1) through the end of the last DATA high phase.
REQ-018 SHALL run each SPI bit as CLK_DIV cycles with spi_clk=0, then CLK_DIV cycles with spi_clk=1.
REQ-019 SHALL update spi_mosi only while spi_clk is low, MSB first; CMD carries the opcode and ADDR carries addr[23:0]; spi_mosi SHALL be 0 in DUMMY, DATA and IDLE.
REQ-020 SHALL sample spi_miso on the clk edge where spi_clk rises.
REQ-021 SHALL assemble rsp_data little-endian: first received byte in bits 7:0, each byte MSB first.
REQ-022 SHALL pulse rsp_valid for exactly one cycle in the cycle spi_csb returns high; latency from acceptance SHALL be 1+2*CLK_DIV*(64+dummy bits) cycles.
REQ-023 SHALL hold rsp_data stable until the next rsp_valid pulse.
REQ-024 SHALL keep req_ready low from the acceptance cycle until HOLD completes; a req_valid held through the final HOLD cycle SHALL be accepted on the first IDLE cycle.
REQ-025 SHALL use address wrap-around at 0xFFFFFC purely in the flash; the block SHALL NOT increment addresses.

Reset
REQ-026 SHALL, on wb_rst_i, enter IDLE and set spi_csb=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=0 during reset and 1 from the first non-reset cycle.
REQ-027 SHALL, on reset mid-transaction, abort on the next edge: spi_csb high, no rsp_valid pulse, and no HOLD wait.

Configuration
REQ-028 SHALL, with SPI_FLASH_READER_FAST_READ_EN defined, use opcode 0x0B with 8 dummy bits (latency 1+144*CLK_DIV).
REQ-029 SHALL, without SPI_FLASH_READER_FAST_READ_EN, use opcode 0x03 with 0 dummy bits, skipping DUMMY (latency 1+128*CLK_DIV).

Structure
REQ-030 SHALL place the state enum, opcode constants (0x03, 0x0B) and bit-count constants (8/24/8/32) in shared package spi_flash_pkg.
REQ-031 SHALL implement the half-period divider and edge strobes as sub-module spi_clk_gen (ports: enable, rise and fall strobes, spi_clk).

Verification
REQ-032 SHALL verify: flash model bytes 0x00..0x03 = 11 22 33 44; read addr 0x000000 -> rsp_data=0x44332211; MOSI sequence 0x03,00,00,00.
REQ-033 SHALL verify: CLK_DIV=1, read addr 0x000100 -> rsp_valid exactly 129 cycles after acceptance, spi_clk period 2 cycles.
REQ-034 SHALL verify: FAST_READ_EN defined, CLK_DIV=2 -> opcode 0x0B, 8 idle spi_clk cycles, rsp_valid 289 cycles after acceptance.
REQ-035 SHALL verify: req_valid held continuously -> back-to-back reads separated by exactly CS_HOLD cycles of spi_csb high; req_addr changed mid-transaction -> no effect.
REQ-036 SHALL verify: wb_rst_i asserted during ADDR -> spi_csb=1 next cycle, no rsp_valid, and the next read returns correct data.
